// File: rtl/stock_table.sv
// Vending-machine stock table: per-slot {price, count} registers with vend,
// restock/modify writes, an empty-slot mask and a handshaked sequential dump.
module stock_table #(
    parameter int SLOTS   = 8,
    parameter int CNT_W   = 5,
    parameter int PRICE_W = 6,
    localparam int SW     = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int DW     = PRICE_W + CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vend_req,
    input  logic [SW-1:0]      vend_slot,
    output logic               vend_ok,
    output logic               vend_fail,
    output logic [PRICE_W-1:0] vend_price,
    input  logic               wr_en,
    input  logic               wr_add,
    input  logic [SW-1:0]      wr_slot,
    input  logic [CNT_W-1:0]   wr_count,
    input  logic [PRICE_W-1:0] wr_price,
    input  logic               dump_start,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [SW-1:0]      dump_index,
    output logic [DW-1:0]      dump_data,
    output logic               dump_busy,
    output logic               dump_done,
    output logic [SLOTS-1:0]   empty_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dumpState_e;

    localparam logic [SW:0]      SLOTS_L  = (SW + 1)'(SLOTS);
    localparam logic [SW-1:0]    LAST_IDX = SW'(SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0]   count_q [SLOTS];
    logic [CNT_W-1:0]   count_d [SLOTS];
    logic [PRICE_W-1:0] price_q [SLOTS];
    logic [PRICE_W-1:0] price_d [SLOTS];

    logic               vendInRange;
    logic               wrInRange;
    logic               wrCollide;
    logic               vendGo;
    logic [CNT_W-1:0]   vendCount;
    logic [PRICE_W-1:0] vendPriceSel;
    logic [CNT_W-1:0]   wrSelCount;
    logic [CNT_W:0]     wrSum;
    logic [CNT_W-1:0]   wrNewCount;

    logic               vendOk_q;
    logic               vendFail_q;
    logic [PRICE_W-1:0] vendPrice_q;

    dumpState_e         state_q, state_d;
    logic [SW-1:0]      dumpIdx_q, dumpIdx_d;
    logic [DW-1:0]      dumpData_q, dumpData_d;
    logic               loadEn;
    logic [SW-1:0]      loadIdx;

    // A write to the same slot wins over a vend, so the vend is refused.
    always_comb begin
        vendInRange  = {1'b0, vend_slot} < SLOTS_L;
        wrInRange    = {1'b0, wr_slot} < SLOTS_L;
        vendCount    = '0;
        vendPriceSel = '0;
        wrSelCount   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (vend_slot == SW'(i)) begin
                vendCount    = count_q[i];
                vendPriceSel = price_q[i];
            end
            if (wr_slot == SW'(i)) begin
                wrSelCount = count_q[i];
            end
        end
        wrCollide = wr_en && wrInRange && (wr_slot == vend_slot);
        vendGo    = vend_req && vendInRange && (vendCount != '0) && !wrCollide;
        wrSum     = {1'b0, wrSelCount} + {1'b0, wr_count};
        if (wr_add) begin
            wrNewCount = wrSum[CNT_W] ? CNT_MAX : wrSum[CNT_W-1:0];
        end else begin
            wrNewCount = wr_count;
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            count_d[i] = count_q[i];
            price_d[i] = price_q[i];
            if (wr_en && wrInRange && (wr_slot == SW'(i))) begin
                count_d[i] = wrNewCount;
                price_d[i] = wr_price;
            end else if (vendGo && (vend_slot == SW'(i))) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                count_q[i] <= '0;
                price_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                count_q[i] <= count_d[i];
                price_q[i] <= price_d[i];
            end
        end
    end

    // Vend response; the reported price is held until the next request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vendOk_q    <= 1'b0;
            vendFail_q  <= 1'b0;
            vendPrice_q <= '0;
        end else begin
            vendOk_q   <= vendGo;
            vendFail_q <= vend_req && !vendGo;
            if (vend_req) begin
                vendPrice_q <= vendInRange ? vendPriceSel : '0;
            end
        end
    end

    assign vend_ok    = vendOk_q;
    assign vend_fail  = vendFail_q;
    assign vend_price = vendPrice_q;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            empty_mask[i] = (count_q[i] == '0);
        end
    end

    // Dump words are snapshotted on index load so stalls see stable data.
    always_comb begin
        state_d    = state_q;
        dumpIdx_d  = dumpIdx_q;
        dumpData_d = dumpData_q;
        loadEn     = 1'b0;
        loadIdx    = '0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SEND;
                    loadEn  = 1'b1;
                    loadIdx = '0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (dumpIdx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        loadEn  = 1'b1;
                        loadIdx = dumpIdx_q + SW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (loadEn) begin
            dumpIdx_d = loadIdx;
            for (int i = 0; i < SLOTS; i++) begin
                if (loadIdx == SW'(i)) begin
                    dumpData_d = {price_q[i], count_q[i]};
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dumpIdx_q  <= '0;
            dumpData_q <= '0;
        end else begin
            state_q    <= state_d;
            dumpIdx_q  <= dumpIdx_d;
            dumpData_q <= dumpData_d;
        end
    end

    assign dump_valid = (state_q == SEND);
    assign dump_busy  = (state_q == SEND) || (state_q == DONE);
    assign dump_done  = (state_q == DONE);
    assign dump_index = dumpIdx_q;
    assign dump_data  = dumpData_q;

endmodule

// File: tb/tb_stock_table.sv
// Self-checking bench for stock_table: directed scenarios plus random traffic
// compared every cycle against a slot-array reference model.
module tb_stock_table;

    logic        clock;
    logic        reset;
    logic        vendReq;
    logic [2:0]  vendSlot;
    logic        vendOk, vendFail;
    logic [5:0]  vendPrice;
    logic        wrEn, wrAdd;
    logic [2:0]  wrSlot;
    logic [4:0]  wrCount;
    logic [5:0]  wrPrice;
    logic        dumpStart, dumpValid, dumpReady, dumpBusy, dumpDone;
    logic [2:0]  dumpIndex;
    logic [10:0] dumpData;
    logic [7:0]  emptyMask;

    logic        v5Req;
    logic [2:0]  v5Slot;
    logic        v5Ok, v5Fail;
    logic [5:0]  v5Price;
    logic        w5En;
    logic [2:0]  w5Slot;
    logic [4:0]  w5Count;
    logic [5:0]  w5Price;
    logic        d5Valid, d5Busy, d5Done;
    logic [2:0]  d5Index;
    logic [10:0] d5Data;
    logic [4:0]  e5Mask;

    int unsigned checks;
    int unsigned failures;

    int mCount [8];
    int mPrice [8];
    int mPhase;
    int mIdx;
    int mData;
    int mOk, mFail, mVendPrice;

    int gotIdx [16];
    int gotData [16];
    int gotCnt;

    stock_table dut (
        .clock(clock), .reset(reset),
        .vend_req(vendReq), .vend_slot(vendSlot), .vend_ok(vendOk),
        .vend_fail(vendFail), .vend_price(vendPrice),
        .wr_en(wrEn), .wr_add(wrAdd), .wr_slot(wrSlot),
        .wr_count(wrCount), .wr_price(wrPrice),
        .dump_start(dumpStart), .dump_valid(dumpValid), .dump_ready(dumpReady),
        .dump_index(dumpIndex), .dump_data(dumpData), .dump_busy(dumpBusy),
        .dump_done(dumpDone), .empty_mask(emptyMask)
    );

    stock_table #(.SLOTS(5)) dut5 (
        .clock(clock), .reset(reset),
        .vend_req(v5Req), .vend_slot(v5Slot), .vend_ok(v5Ok),
        .vend_fail(v5Fail), .vend_price(v5Price),
        .wr_en(w5En), .wr_add(1'b0), .wr_slot(w5Slot),
        .wr_count(w5Count), .wr_price(w5Price),
        .dump_start(1'b0), .dump_valid(d5Valid), .dump_ready(1'b1),
        .dump_index(d5Index), .dump_data(d5Data), .dump_busy(d5Busy),
        .dump_done(d5Done), .empty_mask(e5Mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mCount[i] = 0;
            mPrice[i] = 0;
        end
        mPhase = 0; mIdx = 0; mData = 0;
        mOk = 0; mFail = 0; mVendPrice = 0;
    endtask

    // One clock edge of the reference: everything reads the pre-edge table.
    task automatic modelEdge();
        int oc [8];
        int op [8];
        int ok;
        for (int i = 0; i < 8; i++) begin
            oc[i] = mCount[i];
            op[i] = mPrice[i];
        end
        ok = 0;
        if (vendReq) begin
            ok = (oc[vendSlot] > 0) && !(wrEn && wrSlot == vendSlot);
            mVendPrice = op[vendSlot];
        end
        mOk   = vendReq && ok;
        mFail = vendReq && !ok;
        if (mPhase == 0) begin
            if (dumpStart) begin
                mPhase = 1; mIdx = 0; mData = op[0] * 32 + oc[0];
            end
        end else if (mPhase == 1) begin
            if (dumpReady) begin
                if (mIdx == 7) mPhase = 2;
                else begin
                    mIdx = mIdx + 1;
                    mData = op[mIdx] * 32 + oc[mIdx];
                end
            end
        end else begin
            mPhase = 0;
        end
        if (wrEn) begin
            mPrice[wrSlot] = wrPrice;
            if (wrAdd) mCount[wrSlot] = (oc[wrSlot] + wrCount > 31) ? 31 : oc[wrSlot] + wrCount;
            else       mCount[wrSlot] = wrCount;
        end
        if (mOk) mCount[vendSlot] = mCount[vendSlot] - 1;
    endtask

    task automatic compareAll();
        logic [7:0] expMask;
        for (int i = 0; i < 8; i++) expMask[i] = (mCount[i] == 0);
        check("vend_ok", vendOk, mOk);
        check("vend_fail", vendFail, mFail);
        check("vend_price", vendPrice, mVendPrice);
        check("empty_mask", emptyMask, expMask);
        check("dump_valid", dumpValid, mPhase == 1);
        check("dump_busy", dumpBusy, mPhase != 0);
        check("dump_done", dumpDone, mPhase == 2);
        check("dump_index", dumpIndex, mIdx);
        check("dump_data", dumpData, mData);
    endtask

    task automatic applyStimulus();
        @(posedge clock);
        if (reset) modelReset();
        else modelEdge();
        #1;
        compareAll();
        vendReq = 1'b0; wrEn = 1'b0; dumpStart = 1'b0;
        v5Req = 1'b0; w5En = 1'b0;
    endtask

    task automatic doWrite(input int slot, input int cnt, input int price, input bit add);
        wrEn = 1'b1; wrSlot = 3'(slot); wrCount = 5'(cnt); wrPrice = 6'(price); wrAdd = add;
        applyStimulus();
    endtask

    task automatic doVend(input int slot);
        vendReq = 1'b1; vendSlot = 3'(slot);
        applyStimulus();
    endtask

    // Full dump; a second dump_start is pulsed while busy and must be ignored.
    task automatic runDump(input bit toggle, output int doneCnt, output int cycles);
        doneCnt = 0;
        gotCnt = 0;
        dumpStart = 1'b1; dumpReady = 1'b1;
        applyStimulus();
        cycles = 1;
        for (int cyc = 0; cyc < 40 && doneCnt == 0; cyc++) begin
            dumpReady = toggle ? (cyc % 2 == 0) : 1'b1;
            if (cyc == 3) dumpStart = 1'b1;
            if (dumpValid && dumpReady && gotCnt < 16) begin
                gotIdx[gotCnt] = dumpIndex;
                gotData[gotCnt] = dumpData;
                gotCnt++;
            end
            applyStimulus();
            cycles++;
            if (dumpDone) doneCnt++;
        end
        dumpReady = 1'b0;
        applyStimulus();
        if (dumpDone) doneCnt++;
        check("dump_word_count", gotCnt, 8);
        for (int i = 0; i < 8; i++) check("dump_order", gotIdx[i], i);
    endtask

    initial begin
        int doneCnt, cycles;
        logic [10:0] held;
        checks = 0; failures = 0;
        vendReq = 0; vendSlot = 0; wrEn = 0; wrAdd = 0; wrSlot = 0; wrCount = 0; wrPrice = 0;
        dumpStart = 0; dumpReady = 0;
        v5Req = 0; v5Slot = 0; w5En = 0; w5Slot = 0; w5Count = 0; w5Price = 0;
        modelReset();
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        check("reset_mask", emptyMask, 8'hFF);
        reset = 1'b0;
        applyStimulus();

        // Basic vend sequence: ok, ok, fail with constant price.
        doWrite(3, 2, 25, 1'b0);
        doVend(3);
        check("v1_ok", vendOk, 1); check("v1_price", vendPrice, 25);
        doVend(3);
        check("v2_ok", vendOk, 1); check("v2_mask3", emptyMask[3], 1);
        doVend(3);
        check("v3_fail", vendFail, 1); check("v3_price", vendPrice, 25);

        // Saturating add and same-slot write/vend collision.
        doWrite(5, 30, 7, 1'b0);
        doWrite(5, 5, 7, 1'b1);
        doVend(5);
        check("sat_vend_ok", vendOk, 1);
        doWrite(2, 1, 9, 1'b0);
        wrEn = 1'b1; wrSlot = 3'd2; wrCount = 5'd4; wrPrice = 6'd9; wrAdd = 1'b0;
        vendReq = 1'b1; vendSlot = 3'd2;
        applyStimulus();
        check("collide_fail", vendFail, 1);
        runDump(1'b0, doneCnt, cycles);
        check("dump_cycles", cycles, 9);
        check("dump_done_once", doneCnt, 1);
        check("slot5_word", gotData[5], 7 * 32 + 30);
        check("slot2_word", gotData[2], 9 * 32 + 4);
        check("slot3_word", gotData[3], 25 * 32 + 0);

        // Load {i,i} and dump with a stalling consumer.
        for (int i = 0; i < 8; i++) doWrite(i, i, i, 1'b0);
        runDump(1'b1, doneCnt, cycles);
        check("stall_done_once", doneCnt, 1);
        for (int i = 0; i < 8; i++) check("stall_word", gotData[i], i * 32 + i);

        // Vend on slot 4 while its dump word is stalled.
        dumpStart = 1'b1; dumpReady = 1'b1;
        applyStimulus();
        for (int n = 0; n < 20 && dumpIndex != 3'd4; n++) applyStimulus();
        check("reach_idx4", dumpIndex, 4);
        held = dumpData;
        dumpReady = 1'b0; vendReq = 1'b1; vendSlot = 3'd4;
        applyStimulus();
        check("stall_vend_ok", vendOk, 1);
        check("stall_hold", dumpData, held);
        applyStimulus();
        check("stall_hold2", dumpData, held);
        dumpReady = 1'b1;
        for (int n = 0; n < 20 && !dumpDone; n++) applyStimulus();
        check("finish_done", dumpDone, 1);
        applyStimulus();
        runDump(1'b0, doneCnt, cycles);
        check("slot4_after_vend", gotData[4], 4 * 32 + 3);

        // Asynchronous reset in the middle of a dump.
        dumpStart = 1'b1; dumpReady = 1'b1;
        applyStimulus();
        for (int n = 0; n < 20 && dumpIndex != 3'd3; n++) applyStimulus();
        check("reach_idx3", dumpIndex, 3);
        #2 reset = 1'b1;
        #1;
        check("async_valid", dumpValid, 0);
        check("async_busy", dumpBusy, 0);
        check("async_mask", emptyMask, 8'hFF);
        modelReset();
        applyStimulus();
        reset = 1'b0;
        dumpReady = 1'b1;
        applyStimulus();
        check("no_done_after_reset", dumpDone, 0);

        // Asynchronous reset right after a vend response.
        doWrite(1, 3, 11, 1'b0);
        doVend(1);
        check("pre_reset_ok", vendOk, 1);
        #2 reset = 1'b1;
        #1;
        check("async_vend_ok", vendOk, 0);
        check("async_vend_price", vendPrice, 0);
        modelReset();
        applyStimulus();
        reset = 1'b0;
        applyStimulus();

        // Five-slot instance: out-of-range writes/vends.
        w5En = 1'b1; w5Slot = 3'd6; w5Count = 5'd3; w5Price = 6'd5;
        applyStimulus();
        check("s5_oob_write", e5Mask, 5'h1F);
        w5En = 1'b1; w5Slot = 3'd4; w5Count = 5'd1; w5Price = 6'd9;
        applyStimulus();
        check("s5_write_mask", e5Mask, 5'h0F);
        v5Req = 1'b1; v5Slot = 3'd4;
        applyStimulus();
        check("s5_vend_ok", v5Ok, 1); check("s5_vend_price", v5Price, 9);
        check("s5_mask_after", e5Mask, 5'h1F);
        v5Req = 1'b1; v5Slot = 3'd6;
        applyStimulus();
        check("s5_oob_fail", v5Fail, 1); check("s5_oob_ok", v5Ok, 0);
        check("s5_oob_price", v5Price, 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            vendReq   = 1'($urandom_range(0, 1));
            vendSlot  = 3'($urandom_range(0, 7));
            wrEn      = ($urandom_range(0, 2) == 0);
            wrAdd     = 1'($urandom_range(0, 1));
            wrSlot    = 3'($urandom_range(0, 7));
            wrCount   = 5'($urandom_range(0, 31));
            wrPrice   = 6'($urandom_range(0, 63));
            dumpStart = ($urandom_range(0, 7) == 0);
            dumpReady = 1'($urandom_range(0, 1));
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stock_table.md
STOCK_TABLE -- requirements
Module: stock_table

Interface
REQ-001 SHALL have parameter SLOTS, default 8: number of product slots, 2..64.
REQ-002 SHALL have parameter CNT_W, default 5: per-slot stock count width.
REQ-003 SHALL have parameter PRICE_W, default 6: per-slot price width; SW = max(1, clog2(SLOTS)); DW = PRICE_W+CNT_W (default 11).
REQ-004 SHALL have ports:
  clock  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high.
  vend_req  in  1  request to dispense one item.
  vend_slot  in  SW  slot for vend_req.
  vend_ok  out  1  vend accepted (1-cycle pulse).
  vend_fail  out  1  vend rejected (1-cycle pulse).
  vend_price  out  PRICE_W  price of vended slot, valid with vend_ok/vend_fail.
  wr_en  in  1  restock/modify write strobe.
  wr_add  in  1  1: add wr_count to stock; 0: overwrite stock.
  wr_slot  in  SW  slot for write.
  wr_count  in  CNT_W  count operand.
  wr_price  in  PRICE_W  new price (always overwritten on write).
  dump_start  in  1  start sequential readout of all slots.
  dump_valid  out  1  dump word presented.
  dump_ready  in  1  consumer accepts dump word.
  dump_index  out  SW  slot number of dump word.
  dump_data  out  DW  {price, count} of that slot.
  dump_busy  out  1  dump in progress.
  dump_done  out  1  1-cycle pulse after last word accepted.
  empty_mask  out  SLOTS  bit i = 1 when slot i count is 0.

Function
REQ-005 SHALL hold SLOTS entries of {price[PRICE_W], count[CNT_W]} in registers.
REQ-006 Vend: vend_req at edge k SHALL, at edge k, decrement count and assert vend_ok during cycle k+1 when slot valid (< SLOTS) and count > 0.
REQ-007 Vend on count 0 or slot >= SLOTS SHALL assert vend_fail in cycle k+1, table unchanged; vend_ok and vend_fail never both high.
REQ-008 vend_price SHALL carry the slot's price sampled at edge k (0 if slot out of range); held until next vend_req.
REQ-009 Write: wr_en at edge k SHALL update slot at edge k; wr_add=0 -> count=wr_count; wr_add=1 -> count=min(count+wr_count, 2^CNT_W-1) (saturate, no wrap).
REQ-010 Write to wr_slot >= SLOTS SHALL be ignored.
REQ-011 Simultaneous vend and write to same slot: write SHALL take effect, vend SHALL report vend_fail; different slots both proceed.
REQ-012 empty_mask SHALL be registered-state derived (combinational from counts), reflecting counts after each edge.
REQ-013 Dump FSM states IDLE, SEND, DONE; IDLE --dump_start--> SEND with index 0 at next edge.
REQ-014 In SEND, dump_valid=1; dump_data captured into an output register when index loads, stable while dump_valid && !dump_ready even if the table changes.
REQ-015 On dump_valid && dump_ready: index < SLOTS-1 -> index+1 and recapture; index = SLOTS-1 -> DONE.
REQ-016 DONE SHALL last one cycle with dump_done=1, dump_valid=0, then IDLE; dump_busy=1 in SEND and DONE.
REQ-017 dump_start while dump_busy SHALL be ignored; vend/write continue during dump.
REQ-018 Throughput: with dump_ready held 1, one word per cycle; full dump = SLOTS+1 cycles from dump_start to dump_done (inclusive of DONE).

Reset
REQ-019 reset high SHALL asynchronously clear all counts and prices to 0, empty_mask to all ones, FSM to IDLE, dump_index/dump_data to 0, all strobes (vend_ok, vend_fail, dump_valid, dump_done, dump_busy) and vend_price to 0.
REQ-020 Reset asserted mid-dump or mid-vend SHALL abort immediately; no dump_done pulse, no pending vend response after release.

Verification
REQ-021 Reset, write slot 3 count=2 price=25 (wr_add=0), vend slot 3 three times -> ok, ok, fail; vend_price=25 each; empty_mask[3]=1 after second vend.
REQ-022 Slot 5 count=30 (CNT_W=5), wr_add=1 wr_count=5 -> count=31 (saturated); vend slot 5 -> count 30.
REQ-023 Same-cycle write slot 2 count=4 and vend slot 2 (prior count 1) -> vend_fail, count=4.
REQ-024 Load slots 0..7 with {price=i, count=i}, dump_start with dump_ready toggling 1,0 -> 8 words indices 0..7 in order, data stable during stalls, dump_done once; second dump_start during busy ignored.
REQ-025 Vend slot 4 while dump holds index 4 stalled (dump_ready=0) -> dump_data unchanged until accepted; next dump shows decremented count.
REQ-026 Assert reset at dump index 3 -> dump_valid/dump_busy drop immediately, all counts 0, no dump_done; SLOTS=5 instance: vend_slot=6 -> vend_fail, vend_price=0.
